// File: rtl/display_source_switch.sv
// Glitch-free N-way selector for VGA (RGB/HS/VS) and seven-segment sources; switches only at vsync, then blanks.
// Optional macro SRC_SWITCH_TIMEOUT_EN forces a stalled switch after TIMEOUT_CYC cycles without a vsync.
module display_source_switch #(
    parameter int NUM_SRC      = 4,
    parameter int RGB_W        = 12,
    parameter int SEG_SEL_W    = 4,
    parameter int SEG_W        = 7,
    parameter int BLANK_FRAMES = 1,
    parameter int DEFAULT_SRC  = 0,
    parameter int TIMEOUT_CYC  = 2000000,
    localparam int SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [SEL_W-1:0]              sel_in,
    input  logic [NUM_SRC*RGB_W-1:0]      rgb_in,
    input  logic [NUM_SRC-1:0]            hs_in,
    input  logic [NUM_SRC-1:0]            vs_in,
    input  logic [NUM_SRC*SEG_SEL_W-1:0]  seg_sel_in,
    input  logic [NUM_SRC*SEG_W-1:0]      seg_led_in,
    output logic [RGB_W-1:0]              rgb_out,
    output logic                          hs_out,
    output logic                          vs_out,
    output logic [SEG_SEL_W-1:0]          seg_sel_out,
    output logic [SEG_W-1:0]              seg_led_out,
    output logic [SEL_W-1:0]              active_src,
    output logic                          switching
);

    localparam int BCNT_W = $clog2(BLANK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_STEADY  = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SEL_W-1:0]       r_active_src;
    logic [SEL_W-1:0]       r_target;
    logic                   r_pending;
    logic                   r_vs_prev;
    logic [BCNT_W-1:0]      r_blank_cnt;
    logic                   r_switching;
    logic [RGB_W-1:0]       r_rgb_out;
    logic                   r_hs_out;
    logic                   r_vs_out;
    logic [SEG_SEL_W-1:0]   r_seg_sel_out;
    logic [SEG_W-1:0]       r_seg_led_out;

    logic                   w_sel_valid;
    logic                   w_req;
    logic [SEL_W-1:0]       w_next_tgt;
    logic                   w_vs_cur;
    logic                   w_vs_fall;
    logic                   w_to_exp;
    logic                   w_event;
    logic [RGB_W-1:0]       w_rgb_sel;
    logic [SEG_SEL_W-1:0]   w_seg_sel_sel;
    logic [SEG_W-1:0]       w_seg_led_sel;

    assign w_sel_valid = (32'(sel_in) < 32'(NUM_SRC));
    assign w_req       = w_sel_valid && (sel_in != r_active_src);
    assign w_next_tgt  = w_sel_valid ? sel_in : r_target;
    assign w_vs_cur    = vs_in[r_active_src];
    assign w_vs_fall   = r_vs_prev && !w_vs_cur;
    assign w_event     = w_vs_fall || w_to_exp;

`ifdef SRC_SWITCH_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 20) ? $clog2(TIMEOUT_CYC + 1) : 20;
    logic [TO_W-1:0] r_to_cnt;

    assign w_to_exp = (r_state != ST_STEADY) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Per-frame watchdog: restarts on every frame boundary and whenever no switch is in flight
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if ((r_state == ST_STEADY) || w_event ||
                     ((r_state == ST_WAIT_VS) && (w_next_tgt == r_active_src))) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    // Without the watchdog a switch waits for a real vsync; expression is constant false
    assign w_to_exp = (TIMEOUT_CYC < 0);
`endif

    // Source data selection for the output registers
    always_comb begin
        w_rgb_sel     = rgb_in[r_active_src*RGB_W +: RGB_W];
        w_seg_sel_sel = seg_sel_in[r_active_src*SEG_SEL_W +: SEG_SEL_W];
        w_seg_led_sel = seg_led_in[r_active_src*SEG_W +: SEG_W];
    end

    // Switch controller and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= ST_STEADY;
            r_active_src  <= SEL_W'(DEFAULT_SRC);
            r_target      <= SEL_W'(DEFAULT_SRC);
            r_pending     <= 1'b0;
            r_vs_prev     <= 1'b1;
            r_blank_cnt   <= {BCNT_W{1'b0}};
            r_switching   <= 1'b0;
            r_rgb_out     <= {RGB_W{1'b0}};
            r_hs_out      <= 1'b1;
            r_vs_out      <= 1'b1;
            r_seg_sel_out <= {SEG_SEL_W{1'b0}};
            r_seg_led_out <= {SEG_W{1'b0}};
        end else begin
            r_vs_prev <= w_vs_cur;
            r_hs_out  <= hs_in[r_active_src];
            r_vs_out  <= w_vs_cur;
            if (r_state == ST_BLANK) begin
                r_rgb_out     <= {RGB_W{1'b0}};
                r_seg_sel_out <= {SEG_SEL_W{1'b0}};
                r_seg_led_out <= {SEG_W{1'b0}};
            end else begin
                r_rgb_out     <= w_rgb_sel;
                r_seg_sel_out <= w_seg_sel_sel;
                r_seg_led_out <= w_seg_led_sel;
            end

            case (r_state)
                ST_STEADY: begin
                    if (w_req) begin
                        r_target    <= sel_in;
                        r_state     <= ST_WAIT_VS;
                        r_switching <= 1'b1;
                    end
                end
                ST_WAIT_VS: begin
                    r_target <= w_next_tgt;
                    if (w_next_tgt == r_active_src) begin
                        r_state     <= ST_STEADY;
                        r_switching <= 1'b0;
                    end else if (w_event) begin
                        // Re-seed the edge detector from the new source so its level is not seen as an edge
                        r_active_src <= w_next_tgt;
                        r_vs_prev    <= vs_in[w_next_tgt];
                        r_blank_cnt  <= BCNT_W'(BLANK_FRAMES);
                        r_state      <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (w_req) begin
                        r_pending <= 1'b1;
                        r_target  <= sel_in;
                    end
                    if (w_event) begin
                        if (r_blank_cnt == BCNT_W'(1)) begin
                            r_blank_cnt <= {BCNT_W{1'b0}};
                            r_pending   <= 1'b0;
                            r_state     <= (r_pending || w_req) ? ST_WAIT_VS : ST_STEADY;
                            r_switching <= r_pending || w_req;
                        end else begin
                            r_blank_cnt <= r_blank_cnt - BCNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_STEADY;
                    r_switching <= 1'b0;
                end
            endcase
        end
    end

    assign rgb_out     = r_rgb_out;
    assign hs_out      = r_hs_out;
    assign vs_out      = r_vs_out;
    assign seg_sel_out = r_seg_sel_out;
    assign seg_led_out = r_seg_led_out;
    assign active_src  = r_active_src;
    assign switching   = r_switching;

endmodule
